pipeline_control: RTL and testbench

Central sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB). It owns every stage clock enable and flush, including the `flush` input of the decode stage. It detects read-after-write and load-use hazards against the registers the ID instruction reads, and it resolves ID-stage jump redirects. It also freezes the pipeline while instruction or data memory is not ready.

---
 rtl/pipeline_control_pkg.sv | 34 +++
 rtl/pipeline_control_if.sv | 63 ++++++
 rtl/pipeline_control_hazard_detect.sv | 67 ++++++
 rtl/pipeline_control.sv | 159 +++++++++++++++
 tb/tb_pipeline_control.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared pipeline definitions: register/data widths, control FSM states,
// forward selects, PC selects and the register-match helper.
package riscv_definitions;

  typedef logic [4:0]  regAddr_t;
  typedef logic [31:0] dataBus_u;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    DMEM_WAIT = 2'd2,
    IMEM_WAIT = 2'd3
  } ctrlState_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwdSel_e;

  typedef enum logic {
    PC_SEQ  = 1'b0,
    PC_JUMP = 1'b1
  } pcSel_e;

  localparam dataBus_u STALL_CNT_MAX = 32'hFFFF_FFFF;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic used, input regAddr_t src,
                                     input regAddr_t dst, input logic wr);
    return used && (src != 5'd0) && (src == dst) && wr;
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Bundle between the pipeline datapath and its sequencer; the forward selects
// exist only when FORWARDING_EN is defined.
interface pipeline_control_if;
  import riscv_definitions::*;

  regAddr_t rs1_addr_id;
  regAddr_t rs2_addr_id;
  logic     rs1_used_id;
  logic     rs2_used_id;
  logic     jump_src_id;
  logic     branch_taken;
  regAddr_t rd0_addr_ex;
  logic     rd0_wr_en_ex;
  logic     data_rd_en_ex;
  regAddr_t rd0_addr_mem;
  logic     rd0_wr_en_mem;
  logic     data_rd_en_mem;
  logic     data_wr_en_mem;
  regAddr_t rd0_addr_wb;
  logic     rd0_wr_en_wb;
  logic     imem_ready;
  logic     dmem_ready;

  logic     if_clk_en;
  logic     id_clk_en;
  logic     ex_clk_en;
  logic     mem_clk_en;
  logic     wb_clk_en;
  logic     if_flush;
  logic     id_flush;
  logic     wb_flush;
  pcSel_e   pc_sel;
`ifdef FORWARDING_EN
  fwdSel_e  fwd_a_ex;
  fwdSel_e  fwd_b_ex;
`endif
  dataBus_u stall_cnt;

  modport master (
    output rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id, jump_src_id,
           branch_taken, rd0_addr_ex, rd0_wr_en_ex, data_rd_en_ex,
           rd0_addr_mem, rd0_wr_en_mem, data_rd_en_mem, data_wr_en_mem,
           rd0_addr_wb, rd0_wr_en_wb, imem_ready, dmem_ready,
`ifdef FORWARDING_EN
    input  fwd_a_ex, fwd_b_ex,
`endif
    input  if_clk_en, id_clk_en, ex_clk_en, mem_clk_en, wb_clk_en,
           if_flush, id_flush, wb_flush, pc_sel, stall_cnt
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id, jump_src_id,
           branch_taken, rd0_addr_ex, rd0_wr_en_ex, data_rd_en_ex,
           rd0_addr_mem, rd0_wr_en_mem, data_rd_en_mem, data_wr_en_mem,
           rd0_addr_wb, rd0_wr_en_wb, imem_ready, dmem_ready,
`ifdef FORWARDING_EN
    output fwd_a_ex, fwd_b_ex,
`endif
    output if_clk_en, id_clk_en, ex_clk_en, mem_clk_en, wb_clk_en,
           if_flush, id_flush, wb_flush, pc_sel, stall_cnt
  );

endinterface

// File: rtl/pipeline_control_hazard_detect.sv
// Combinational register comparators: stall decision for the ID instruction and,
// with FORWARDING_EN, EX operand forward selects.
module hazard_detect
  import riscv_definitions::*;
(
  input  regAddr_t rs1_addr_id,
  input  regAddr_t rs2_addr_id,
  input  logic     rs1_used_id,
  input  logic     rs2_used_id,
`ifdef FORWARDING_EN
  input  logic     jump_src_id,
  input  regAddr_t rs1_addr_ex,
  input  regAddr_t rs2_addr_ex,
`endif
  input  regAddr_t rd0_addr_ex,
  input  logic     rd0_wr_en_ex,
  input  logic     data_rd_en_ex,
  input  regAddr_t rd0_addr_mem,
  input  logic     rd0_wr_en_mem,
  input  regAddr_t rd0_addr_wb,
  input  logic     rd0_wr_en_wb,
`ifdef FORWARDING_EN
  output fwdSel_e  fwd_a,
  output fwdSel_e  fwd_b,
`endif
  output logic     stall
);

  logic ex_wr;
  logic ex_hit;
  logic mem_hit;

  assign ex_wr   = rd0_wr_en_ex | data_rd_en_ex;
  assign ex_hit  = reg_match(rs1_used_id, rs1_addr_id, rd0_addr_ex, ex_wr) |
                   reg_match(rs2_used_id, rs2_addr_id, rd0_addr_ex, ex_wr);
  assign mem_hit = reg_match(rs1_used_id, rs1_addr_id, rd0_addr_mem, rd0_wr_en_mem) |
                   reg_match(rs2_used_id, rs2_addr_id, rd0_addr_mem, rd0_wr_en_mem);

`ifdef FORWARDING_EN
  // Jumps resolve in ID, so they cannot consume values forwarded into EX.
  assign stall = (data_rd_en_ex & ex_hit) | (jump_src_id & (ex_hit | mem_hit));

  always_comb begin
    fwd_a = FWD_NONE;
    if (reg_match(1'b1, rs1_addr_ex, rd0_addr_mem, rd0_wr_en_mem))
      fwd_a = FWD_MEM;
    else if (reg_match(1'b1, rs1_addr_ex, rd0_addr_wb, rd0_wr_en_wb))
      fwd_a = FWD_WB;
  end

  always_comb begin
    fwd_b = FWD_NONE;
    if (reg_match(1'b1, rs2_addr_ex, rd0_addr_mem, rd0_wr_en_mem))
      fwd_b = FWD_MEM;
    else if (reg_match(1'b1, rs2_addr_ex, rd0_addr_wb, rd0_wr_en_wb))
      fwd_b = FWD_WB;
  end
`else
  logic wb_hit;

  // The register file is not write-through, so a WB writer still blocks ID.
  assign wb_hit = reg_match(rs1_used_id, rs1_addr_id, rd0_addr_wb, rd0_wr_en_wb) |
                  reg_match(rs2_used_id, rs2_addr_id, rd0_addr_wb, rd0_wr_en_wb);
  assign stall  = ex_hit | mem_hit | wb_hit;
`endif

endmodule

// File: rtl/pipeline_control.sv
// Five-stage pipeline sequencer: stage enables, flushes, PC select and stall counter.
// FORWARDING_EN enables EX operand forwarding and the reduced hazard stall rules.
module pipeline_control
  import riscv_definitions::*;
(
  input  logic               clk,
  input  logic               rst_n,
  pipeline_control_if.slave  bus
);

  ctrlState_e state;
  ctrlState_e state_nxt;
  logic       hazard_stall;
  logic       dmem_block;
  logic       if_en;
  logic       id_en;
  logic       ex_en;
  logic       mem_en;
  logic       wb_en;
  logic       if_fl;
  logic       id_fl;
  logic       wb_fl;
  pcSel_e     pc_sel;
  dataBus_u   stall_cnt;

`ifdef FORWARDING_EN
  regAddr_t   rs1_addr_ex;
  regAddr_t   rs2_addr_ex;
  fwdSel_e    fwd_a;
  fwdSel_e    fwd_b;
`endif

  hazard_detect u_hazard (
    .rs1_addr_id   (bus.rs1_addr_id),
    .rs2_addr_id   (bus.rs2_addr_id),
    .rs1_used_id   (bus.rs1_used_id),
    .rs2_used_id   (bus.rs2_used_id),
`ifdef FORWARDING_EN
    .jump_src_id   (bus.jump_src_id),
    .rs1_addr_ex   (rs1_addr_ex),
    .rs2_addr_ex   (rs2_addr_ex),
`endif
    .rd0_addr_ex   (bus.rd0_addr_ex),
    .rd0_wr_en_ex  (bus.rd0_wr_en_ex),
    .data_rd_en_ex (bus.data_rd_en_ex),
    .rd0_addr_mem  (bus.rd0_addr_mem),
    .rd0_wr_en_mem (bus.rd0_wr_en_mem),
    .rd0_addr_wb   (bus.rd0_addr_wb),
    .rd0_wr_en_wb  (bus.rd0_wr_en_wb),
`ifdef FORWARDING_EN
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
`endif
    .stall         (hazard_stall)
  );

  assign dmem_block = (bus.data_rd_en_mem | bus.data_wr_en_mem) & ~bus.dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if_en     = 1'b1;
    id_en     = 1'b1;
    ex_en     = 1'b1;
    mem_en    = 1'b1;
    wb_en     = 1'b1;
    if_fl     = 1'b0;
    id_fl     = 1'b0;
    wb_fl     = 1'b0;
    pc_sel    = PC_SEQ;
    case (state)
      BOOT: begin
        if_fl     = 1'b1;
        id_fl     = 1'b1;
        wb_fl     = 1'b1;
        state_nxt = RUN;
      end
      DMEM_WAIT: begin
        if (!bus.dmem_ready) begin
          if_en  = 1'b0;
          id_en  = 1'b0;
          ex_en  = 1'b0;
          mem_en = 1'b0;
          wb_fl  = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        // RUN and IMEM_WAIT share the priority chain; IMEM_WAIT only adds the hold.
        if (dmem_block) begin
          if_en     = 1'b0;
          id_en     = 1'b0;
          ex_en     = 1'b0;
          mem_en    = 1'b0;
          wb_fl     = 1'b1;
          state_nxt = DMEM_WAIT;
        end else if (state == IMEM_WAIT && !bus.imem_ready) begin
          if_en = 1'b0;
          if_fl = 1'b1;
        end else if (hazard_stall) begin
          if_en     = 1'b0;
          id_en     = 1'b0;
          id_fl     = 1'b1;
          state_nxt = RUN;
        end else if (bus.branch_taken) begin
          pc_sel    = PC_JUMP;
          if_fl     = 1'b1;
          state_nxt = RUN;
        end else if (!bus.imem_ready) begin
          if_en     = 1'b0;
          if_fl     = 1'b1;
          state_nxt = IMEM_WAIT;
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (!if_en && stall_cnt != STALL_CNT_MAX)
      stall_cnt <= stall_cnt + 32'd1;
  end

`ifdef FORWARDING_EN
  // Source addresses follow the instruction into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_addr_ex <= '0;
      rs2_addr_ex <= '0;
    end else if (ex_en) begin
      rs1_addr_ex <= bus.rs1_addr_id;
      rs2_addr_ex <= bus.rs2_addr_id;
    end
  end

  assign bus.fwd_a_ex = (state == BOOT) ? FWD_NONE : fwd_a;
  assign bus.fwd_b_ex = (state == BOOT) ? FWD_NONE : fwd_b;
`endif

  assign bus.if_clk_en  = if_en;
  assign bus.id_clk_en  = id_en;
  assign bus.ex_clk_en  = ex_en;
  assign bus.mem_clk_en = mem_en;
  assign bus.wb_clk_en  = wb_en;
  assign bus.if_flush   = if_fl;
  assign bus.id_flush   = id_fl;
  assign bus.wb_flush   = wb_fl;
  assign bus.pc_sel     = pc_sel;
  assign bus.stall_cnt  = stall_cnt;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: directed scenarios plus random traffic
// checked against a behavioural model of the sequencing rules.
module tb_pipeline_control;
  import riscv_definitions::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_control_if bus ();

  pipeline_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  en;        // {if, id, ex, mem, wb}
    logic        if_flush;
    logic        id_flush;
    logic        wb_flush;
    logic        pc_sel;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;

  // Model memory: what the sequencer should remember between cycles.
  bit          m_boot  = 1'b1;
  bit          m_dwait = 1'b0;
  bit          m_iwait = 1'b0;
  logic [31:0] m_cnt   = '0;
  logic [4:0]  m_ex1   = '0;
  logic [4:0]  m_ex2   = '0;

  function automatic bit hit(input bit used, input logic [4:0] src,
                             input logic [4:0] dst, input bit wr);
    return used && src != 0 && src == dst && wr;
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (src != 0 && src == bus.rd0_addr_mem && bus.rd0_wr_en_mem) return 2'b01;
    if (src != 0 && src == bus.rd0_addr_wb && bus.rd0_wr_en_wb)    return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle();
    bus.rs1_addr_id = 0; bus.rs2_addr_id = 0; bus.rs1_used_id = 0; bus.rs2_used_id = 0;
    bus.jump_src_id = 0; bus.branch_taken = 0;
    bus.rd0_addr_ex = 0; bus.rd0_wr_en_ex = 0; bus.data_rd_en_ex = 0;
    bus.rd0_addr_mem = 0; bus.rd0_wr_en_mem = 0; bus.data_rd_en_mem = 0; bus.data_wr_en_mem = 0;
    bus.rd0_addr_wb = 0; bus.rd0_wr_en_wb = 0;
    bus.imem_ready = 1; bus.dmem_ready = 1;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then advance the model.
  task automatic issue();
    exp_t e;
    bit   ex_wr, h_ex, h_mem, h_wb, hz, mem_acc;
    bit   freeze, fstall;
    freeze  = 0;
    fstall  = 0;
    ex_wr   = bus.rd0_wr_en_ex || bus.data_rd_en_ex;
    h_ex    = hit(bus.rs1_used_id, bus.rs1_addr_id, bus.rd0_addr_ex, ex_wr) ||
              hit(bus.rs2_used_id, bus.rs2_addr_id, bus.rd0_addr_ex, ex_wr);
    h_mem   = hit(bus.rs1_used_id, bus.rs1_addr_id, bus.rd0_addr_mem, bus.rd0_wr_en_mem) ||
              hit(bus.rs2_used_id, bus.rs2_addr_id, bus.rd0_addr_mem, bus.rd0_wr_en_mem);
    h_wb    = hit(bus.rs1_used_id, bus.rs1_addr_id, bus.rd0_addr_wb, bus.rd0_wr_en_wb) ||
              hit(bus.rs2_used_id, bus.rs2_addr_id, bus.rd0_addr_wb, bus.rd0_wr_en_wb);
`ifdef FORWARDING_EN
    hz      = (bus.data_rd_en_ex && h_ex) || (bus.jump_src_id && (h_ex || h_mem));
`else
    hz      = h_ex || h_mem || h_wb;
`endif
    mem_acc = bus.data_rd_en_mem || bus.data_wr_en_mem;

    e = '0;
    e.en  = 5'b11111;
    e.cnt = rst_n ? m_cnt : 32'd0;
    if (!rst_n || m_boot) begin
      e.if_flush = 1; e.id_flush = 1; e.wb_flush = 1;
    end else begin
      freeze = m_dwait ? !bus.dmem_ready : (mem_acc && !bus.dmem_ready);
      if (freeze) begin
        e.en = 5'b00001;
        e.wb_flush = 1;
      end else if (!m_dwait) begin
        if (m_iwait && !bus.imem_ready) fstall = 1;
        else if (hz) begin
          e.en[4] = 0; e.en[3] = 0; e.id_flush = 1;
        end else if (bus.branch_taken) begin
          e.pc_sel = 1; e.if_flush = 1;
        end else if (!bus.imem_ready) fstall = 1;
      end
      if (fstall) begin
        e.en[4] = 0; e.if_flush = 1;
      end
`ifdef FORWARDING_EN
      e.fwd_a = fsel(m_ex1);
      e.fwd_b = fsel(m_ex2);
`endif
    end
    exp_q.push_back(e);

    if (!rst_n) begin
      m_boot = 1; m_dwait = 0; m_iwait = 0; m_cnt = 0; m_ex1 = 0; m_ex2 = 0;
    end else begin
      m_boot  = 0;
      m_dwait = freeze;
      m_iwait = fstall;
      if (!e.en[4] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (e.en[2]) begin
        m_ex1 = bus.rs1_addr_id;
        m_ex2 = bus.rs2_addr_id;
      end
    end
  endtask

  // Monitor: outputs are combinational every cycle, so one entry is popped per cycle.
  exp_t        mexp;
  logic [12:0] act_ctl;
  logic [12:0] exp_ctl;
  logic [1:0]  act_fa, act_fb;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      cyc_no++;
      if (exp_q.size() > 0) begin
        mexp = exp_q.pop_front();
`ifdef FORWARDING_EN
        act_fa = bus.fwd_a_ex;
        act_fb = bus.fwd_b_ex;
`else
        act_fa = 2'b00;
        act_fb = 2'b00;
`endif
        act_ctl = {bus.if_clk_en, bus.id_clk_en, bus.ex_clk_en, bus.mem_clk_en, bus.wb_clk_en,
                   bus.if_flush, bus.id_flush, bus.wb_flush, bus.pc_sel, act_fa, act_fb};
        exp_ctl = {mexp.en, mexp.if_flush, mexp.id_flush, mexp.wb_flush, mexp.pc_sel,
                   mexp.fwd_a, mexp.fwd_b};
        checks++;
        if (act_ctl !== exp_ctl) begin
          failures++;
          $display("FAIL ctl cycle=%0d actual en/if/id/wb/pc/fa/fb=%b expected=%b",
                   cyc_no, act_ctl, exp_ctl);
        end
        checks++;
        if (bus.stall_cnt !== mexp.cnt) begin
          failures++;
          $display("FAIL stall_cnt cycle=%0d actual=%0d expected=%0d",
                   cyc_no, bus.stall_cnt, mexp.cnt);
        end
      end
    end
  end

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 5))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd3;
      3:       return 5'd5;
      default: return 5'd7;
    endcase
  endfunction

  logic [31:0] c0, c1;

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset held, then one BOOT cycle, then RUN.
    next(); rst_n = 0; issue();
    next(); rst_n = 0; issue();
    next(); rst_n = 1; issue();
    next(); issue();

    // Load-use on x5.
    next(); bus.rd0_addr_ex = 5; bus.rd0_wr_en_ex = 1; bus.data_rd_en_ex = 1;
            bus.rs1_addr_id = 5; bus.rs1_used_id = 1; issue();
    next(); bus.rd0_addr_mem = 5; bus.rd0_wr_en_mem = 1; bus.data_rd_en_mem = 1;
            bus.rs1_addr_id = 5; bus.rs1_used_id = 1; issue();
    next(); bus.rd0_addr_wb = 5; bus.rd0_wr_en_wb = 1;
            bus.rs1_addr_id = 1; bus.rs1_used_id = 1; issue();
    next(); issue();

    // Taken branch alone, then combined with a hazard on x3.
    next(); bus.branch_taken = 1; issue();
    next(); bus.branch_taken = 1; bus.jump_src_id = 1; bus.rs1_addr_id = 3; bus.rs1_used_id = 1;
            bus.rd0_addr_ex = 3; bus.rd0_wr_en_ex = 1; issue();
    next(); bus.branch_taken = 1; bus.jump_src_id = 1; bus.rs1_addr_id = 3; bus.rs1_used_id = 1;
            issue();

    // Store in MEM with dmem_ready low for three cycles.
    @(negedge clk);
    c0 = bus.stall_cnt;
    idle(); bus.data_wr_en_mem = 1; bus.dmem_ready = 0; issue();
    next(); bus.data_wr_en_mem = 1; bus.dmem_ready = 0; issue();
    next(); bus.data_wr_en_mem = 1; bus.dmem_ready = 0; issue();
    next(); bus.data_wr_en_mem = 1; issue();
    @(negedge clk);
    c1 = bus.stall_cnt;
    checks++;
    if (c1 - c0 != 32'd3) begin
      failures++;
      $display("FAIL dmem_wait_delta actual=%0d expected=3", c1 - c0);
    end
    idle(); issue();

    // Writer to x0 is never a dependency.
    next(); bus.rd0_addr_ex = 0; bus.rd0_wr_en_ex = 1; bus.data_rd_en_ex = 1; bus.jump_src_id = 1;
            bus.rs1_used_id = 1; bus.rs2_used_id = 1; issue();
    next(); bus.rd0_addr_mem = 0; bus.rd0_wr_en_mem = 1; issue();

    // ADD x7 followed by a dependent ADD, writer walking EX -> MEM -> WB.
    @(negedge clk);
    c0 = bus.stall_cnt;
    idle(); bus.rd0_addr_ex = 7; bus.rd0_wr_en_ex = 1; bus.rs2_addr_id = 7; bus.rs2_used_id = 1; issue();
    next(); bus.rd0_addr_mem = 7; bus.rd0_wr_en_mem = 1; bus.rs2_addr_id = 7; bus.rs2_used_id = 1; issue();
    next(); bus.rd0_addr_wb = 7; bus.rd0_wr_en_wb = 1; bus.rs2_addr_id = 7; bus.rs2_used_id = 1; issue();
    next(); bus.rs2_addr_id = 7; bus.rs2_used_id = 1; issue();
    @(negedge clk);
    c1 = bus.stall_cnt;
    checks++;
`ifdef FORWARDING_EN
    if (c1 - c0 != 32'd0) begin
      failures++;
      $display("FAIL add_dep_stalls actual=%0d expected=0", c1 - c0);
    end
`else
    if (c1 - c0 != 32'd3) begin
      failures++;
      $display("FAIL add_dep_stalls actual=%0d expected=3", c1 - c0);
    end
`endif
    idle(); issue();

    // Fetch wait, with a data-memory stall arising during it.
    next(); bus.imem_ready = 0; issue();
    next(); bus.imem_ready = 0; issue();
    next(); bus.imem_ready = 0; bus.data_rd_en_mem = 1; bus.dmem_ready = 0; issue();
    next(); bus.data_rd_en_mem = 1; issue();
    next(); issue();

    // Reset asserted in the middle of a data-memory stall.
    next(); bus.data_wr_en_mem = 1; bus.dmem_ready = 0; issue();
    next(); bus.data_wr_en_mem = 1; bus.dmem_ready = 0; issue();
    next(); bus.data_wr_en_mem = 1; bus.dmem_ready = 0; rst_n = 0; issue();
    next(); rst_n = 1; issue();
    next(); issue();

    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      next();
      rst_n              = ($urandom_range(0, 99) != 0);
      bus.rs1_addr_id    = pick();
      bus.rs2_addr_id    = pick();
      bus.rs1_used_id    = ($urandom_range(0, 3) != 0);
      bus.rs2_used_id    = ($urandom_range(0, 1) != 0);
      bus.jump_src_id    = ($urandom_range(0, 3) == 0);
      bus.branch_taken   = ($urandom_range(0, 4) == 0);
      bus.rd0_addr_ex    = pick();
      bus.rd0_wr_en_ex   = $urandom_range(0, 1);
      bus.data_rd_en_ex  = ($urandom_range(0, 3) == 0);
      bus.rd0_addr_mem   = pick();
      bus.rd0_wr_en_mem  = $urandom_range(0, 1);
      bus.data_rd_en_mem = ($urandom_range(0, 3) == 0);
      bus.data_wr_en_mem = ($urandom_range(0, 3) == 0);
      bus.rd0_addr_wb    = pick();
      bus.rd0_wr_en_wb   = $urandom_range(0, 1);
      bus.imem_ready     = ($urandom_range(0, 4) != 0);
      bus.dmem_ready     = ($urandom_range(0, 3) != 0);
      issue();
    end

    next(); rst_n = 1; issue();
    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
